fwd_hazard_unit: RTL and testbench

- Generates the 2-bit select codes that drive the ALU-operand 3-to-1 muxes in the pipelined CPU, plus the load-use stall request.
- Keeps its own shadow pipeline (ID/EX, EX/MEM, MEM/WB) of destination-register info.
- It is the producer side of the operand-mux select interface: mux code 0 selects the register file, 1 selects the EX/MEM result, 2 selects the MEM/WB result.

---
 rtl/fwd_hazard_unit.sv | 129 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Operand-forwarding select and load-use stall generator for the pipelined
// CPU. A shadow copy of the ID/EX, EX/MEM and MEM/WB destination-register
// information is kept here. The EX instruction's operand-mux selects are
// derived from that copy. Select codes: 0 = register file, 1 = EX/MEM result,
// 2 = MEM/WB result.
// Optional build macro FWD_STALL_CNT_EN adds a saturating 32-bit count of
// stall cycles on port stall_cnt_o.

module fwd_hazard_unit #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  issue_valid_i,
   input  logic [REG_ADDR_W-1:0] issue_rs_i,
   input  logic [REG_ADDR_W-1:0] issue_rt_i,
   input  logic [REG_ADDR_W-1:0] issue_rd_i,
   input  logic                  issue_reg_write_i,
   input  logic                  issue_mem_read_i,
   input  logic                  flush_i,
   output logic [1:0]            fwd_a_o,
   output logic [1:0]            fwd_b_o,
   output logic                  stall_o
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cnt_o
`endif
);

   // Full record for the instruction currently in EX.
   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  mem_read;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
   } stage_rec_t;

   // Past EX only the destination side of a record matters.
   // The source fields and the load flag are dropped there.
   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
   } dest_rec_t;

   stage_rec_t idex_q;
   stage_rec_t idex_next;
   dest_rec_t  exmem_q;
   dest_rec_t  memwb_q;
   logic       load_hazard;

   // True when a later stage will write register r. Register 0 never counts.
   function automatic logic produces(input dest_rec_t s, input logic [REG_ADDR_W-1:0] r);
      return s.valid && s.reg_write && (s.rd == r) && (r != '0);
   endfunction

   // Forwarding selects come only from registered records.
   // Because of that they hold steady across the whole cycle.
   always_comb begin
      fwd_a_o = 2'd0;
      fwd_b_o = 2'd0;
      if (idex_q.valid) begin
         if (produces(exmem_q, idex_q.rs)) begin
            fwd_a_o = 2'd1;
         end else if (produces(memwb_q, idex_q.rs)) begin
            fwd_a_o = 2'd2;
         end
         if (produces(exmem_q, idex_q.rt)) begin
            fwd_b_o = 2'd1;
         end else if (produces(memwb_q, idex_q.rt)) begin
            fwd_b_o = 2'd2;
         end
      end
   end

   // A load in EX whose destination is read by the ID instruction needs one bubble.
   // A flush cancels that bubble, since the ID instruction is squashed anyway.
   always_comb begin
      load_hazard = idex_q.valid && idex_q.mem_read && idex_q.reg_write &&
                    (idex_q.rd != '0) && issue_valid_i &&
                    ((issue_rs_i == idex_q.rd) || (issue_rt_i == idex_q.rd));
      stall_o     = load_hazard && !flush_i;
   end

   // Only a real, unstalled, unflushed ID instruction enters EX.
   // Everything else becomes a bubble.
   always_comb begin
      idex_next = '0;
      if (issue_valid_i && !stall_o && !flush_i) begin
         idex_next.valid     = 1'b1;
         idex_next.reg_write = issue_reg_write_i;
         idex_next.mem_read  = issue_mem_read_i;
         idex_next.rs        = issue_rs_i;
         idex_next.rt        = issue_rt_i;
         idex_next.rd        = issue_rd_i;
      end
   end

   // Advance the shadow pipeline every cycle.
   // Reset empties every stage immediately.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q            <= idex_next;
         exmem_q.valid     <= idex_q.valid;
         exmem_q.reg_write <= idex_q.reg_write;
         exmem_q.rd        <= idex_q.rd;
         memwb_q           <= exmem_q;
      end
   end

`ifdef FWD_STALL_CNT_EN
   // Count stall cycles. The count sticks at all-ones rather than wrapping.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o <= '0;
      end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
// Checks fwd_hazard_unit against a behavioural model of the in-flight
// instructions, using directed scenarios followed by randomized traffic.
// The bench follows the FWD_STALL_CNT_EN macro the same way the design does.

module tb_fwd_hazard_unit;

   logic       clk_i;
   logic       rst_i;
   logic       issue_valid_i;
   logic [4:0] issue_rs_i;
   logic [4:0] issue_rt_i;
   logic [4:0] issue_rd_i;
   logic       issue_reg_write_i;
   logic       issue_mem_read_i;
   logic       flush_i;
   logic [1:0] fwd_a_o;
   logic [1:0] fwd_b_o;
   logic       stall_o;
`ifdef FWD_STALL_CNT_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] model_cnt;
   logic [31:0] cnt_before;
`endif

   int checks;
   int failures;

   // Model of in-flight instructions. Slot 0 = EX, 1 = MEM, 2 = WB.
   // The slot index equals the mux code that would forward from it.
   typedef struct {
      logic       valid;
      logic       rw;
      logic       mr;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } mrec_t;

   mrec_t stage[3];

   logic [1:0] obs_a;
   logic [1:0] obs_b;
   logic       obs_stall;
   logic       exp_stall_last;

   fwd_hazard_unit #(.REG_ADDR_W(5)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .issue_valid_i     (issue_valid_i),
      .issue_rs_i        (issue_rs_i),
      .issue_rt_i        (issue_rt_i),
      .issue_rd_i        (issue_rd_i),
      .issue_reg_write_i (issue_reg_write_i),
      .issue_mem_read_i  (issue_mem_read_i),
      .flush_i           (flush_i),
      .fwd_a_o           (fwd_a_o),
      .fwd_b_o           (fwd_b_o),
      .stall_o           (stall_o)
`ifdef FWD_STALL_CNT_EN
      ,
      .stall_cnt_o       (stall_cnt_o)
`endif
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelClear();
      for (int s = 0; s < 3; s++) begin
         stage[s] = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
      end
`ifdef FWD_STALL_CNT_EN
      model_cnt = 32'd0;
`endif
   endtask

   // Return the youngest older instruction that writes r, or 0 if none does.
   function automatic logic [1:0] modelFwd(input logic [4:0] r);
      if (!stage[0].valid) return 2'd0;
      for (int s = 1; s <= 2; s++) begin
         if (stage[s].valid && stage[s].rw && stage[s].rd == r && r != 5'd0) return s[1:0];
      end
      return 2'd0;
   endfunction

   function automatic logic modelStall();
      if (flush_i || !issue_valid_i) return 1'b0;
      if (!(stage[0].valid && stage[0].mr && stage[0].rw && stage[0].rd != 5'd0)) return 1'b0;
      return (issue_rs_i == stage[0].rd) || (issue_rt_i == stage[0].rd);
   endfunction

   // Drive one ID-stage instruction, compare at mid-cycle, then step the model at the edge.
   task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
      logic exp_stall;
      issue_valid_i     = v;
      issue_rs_i        = rs;
      issue_rt_i        = rt;
      issue_rd_i        = rd;
      issue_reg_write_i = rw;
      issue_mem_read_i  = mr;
      flush_i           = fl;
      @(negedge clk_i);
      exp_stall = modelStall();
      checkOutput("fwd_a", {30'd0, fwd_a_o}, {30'd0, modelFwd(stage[0].rs)});
      checkOutput("fwd_b", {30'd0, fwd_b_o}, {30'd0, modelFwd(stage[0].rt)});
      checkOutput("stall", {31'd0, stall_o}, {31'd0, exp_stall});
`ifdef FWD_STALL_CNT_EN
      checkOutput("stall_cnt", stall_cnt_o, model_cnt);
`endif
      obs_a          = fwd_a_o;
      obs_b          = fwd_b_o;
      obs_stall      = stall_o;
      exp_stall_last = exp_stall;
      @(posedge clk_i);
      if (rst_i) begin
         stage[2] = stage[1];
         stage[1] = stage[0];
         if (v && !exp_stall && !fl) begin
            stage[0] = '{valid: 1'b1, rw: rw, mr: mr, rs: rs, rt: rt, rd: rd};
         end else begin
            stage[0] = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
         end
`ifdef FWD_STALL_CNT_EN
         if (exp_stall && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
`endif
      end
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   logic [4:0] r_rs, r_rt, r_rd;
   logic       r_v, r_rw, r_mr, r_fl;

   // Directed scenarios first, then randomized traffic, then the summary.
   initial begin
      checks    = 0;
      failures  = 0;
      rst_i     = 1'b0;
      issue_valid_i = 1'b0; issue_rs_i = '0; issue_rt_i = '0; issue_rd_i = '0;
      issue_reg_write_i = 1'b0; issue_mem_read_i = 1'b0; flush_i = 1'b0;
      modelClear();

      // While reset is held, all outputs must be zero.
      @(negedge clk_i);
      checkOutput("reset_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      checkOutput("reset_fwd_b", {30'd0, fwd_b_o}, 32'd0);
      checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;

      // Back-to-back: add rd=3, then sub rs=3.
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("b2b_fwd_a", {30'd0, obs_a}, 32'd1);
      checkOutput("b2b_fwd_b", {30'd0, obs_b}, 32'd0);
      drain();

      // Distance two: add rd=3, unrelated, reader with rt=3.
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd1, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("dist2_fwd_b", {30'd0, obs_b}, 32'd2);
      checkOutput("dist2_fwd_a", {30'd0, obs_a}, 32'd0);
      drain();

      // Priority: two writers of r3 back to back. The younger one wins.
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd3, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("prio_fwd_a", {30'd0, obs_a}, 32'd1);
      drain();

      // Zero register: writing r0 never forwards.
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
      checkOutput("zero_fwd_a0", {30'd0, obs_a}, 32'd0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("zero_fwd_a1", {30'd0, obs_a}, 32'd0);
      checkOutput("zero_fwd_b1", {30'd0, obs_b}, 32'd0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("zero_fwd_a2", {30'd0, obs_a}, 32'd0);
      drain();

      // Load-use: lw rd=5, then a reader of r5 that stalls once and is then held.
`ifdef FWD_STALL_CNT_EN
      cnt_before = stall_cnt_o;
`endif
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
      checkOutput("lu_stall_on", {31'd0, obs_stall}, 32'd1);
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
      checkOutput("lu_stall_off", {31'd0, obs_stall}, 32'd0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_fwd_a", {30'd0, obs_a}, 32'd2);
`ifdef FWD_STALL_CNT_EN
      checkOutput("lu_cnt_inc", stall_cnt_o, cnt_before + 32'd1);
`endif
      drain();

      // Flush beats stall: the dependent instruction is squashed and EX gets a bubble.
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b1);
      checkOutput("flush_stall", {31'd0, obs_stall}, 32'd0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("flush_fwd_a", {30'd0, obs_a}, 32'd0);
      checkOutput("flush_fwd_b", {30'd0, obs_b}, 32'd0);
      drain();

      // Asynchronous reset mid-cycle while an r7 writer sits in EX/MEM.
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd7, 5'd1, 5'd13, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("pre_reset_fwd_a", {30'd0, fwd_a_o}, 32'd1);
      rst_i = 1'b0;
      modelClear();
      #1;
      checkOutput("async_reset_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      checkOutput("async_reset_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk_i); #2;
      rst_i = 1'b1;
      applyStimulus(1'b1, 5'd7, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("post_reset_fwd_a", {30'd0, obs_a}, 32'd0);

      // Randomized traffic. A stalled instruction is held, as IF/ID would hold it.
      exp_stall_last = 1'b0;
      r_v = 1'b0; r_rs = '0; r_rt = '0; r_rd = '0; r_rw = 1'b0; r_mr = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!exp_stall_last) begin
            r_v  = ($urandom_range(0, 3) != 0);
            r_rs = 5'($urandom_range(0, 7));
            r_rt = 5'($urandom_range(0, 7));
            r_rd = 5'($urandom_range(0, 7));
            r_rw = ($urandom_range(0, 4) != 0);
            r_mr = ($urandom_range(0, 2) == 0);
         end
         r_fl = ($urandom_range(0, 9) == 0);
         applyStimulus(r_v, r_rs, r_rt, r_rd, r_rw, r_mr, r_fl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
